// File: rtl/key_scan_ctrl_pkg.sv
// Shared types for the key scan controller: scan FSM states and the queued event record.
package key_pkg;

    typedef enum logic {
        IDLE,
        SCAN
    } scan_state_t;

    localparam int unsigned EVT_DEPTH = 4;

    // Index field is sized for up to 256 keys; the top narrows it to its own index width.
    localparam int unsigned EVT_IDX_W = 8;

    typedef struct packed {
        logic                 press;
        logic [EVT_IDX_W-1:0] idx;
    } evt_t;

endpackage

// File: rtl/key_scan_ctrl_evt_fifo.sv
// Small count-based event FIFO. The head is presented straight from storage;
// a push that finds no room is dropped and latches a sticky overflow flag.
module evt_fifo
    import key_pkg::*;
#(
    parameter int unsigned WIDTH = $bits(evt_t),
    parameter int unsigned DEPTH = EVT_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic             ovf
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             empty;
    logic             full;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot the push needs.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push && !do_push) begin
                ovf <= 1'b1;
            end
        end
    end

    assign dout  = mem[rd_ptr];
    assign valid = !empty;

endmodule

// File: rtl/key_scan_ctrl.sv
// Keyboard scan controller: synchronizes raw keys, debounces one key per clock after each
// sample tick, reports the lowest pressed key, and queues press/release events.
module key_scan_ctrl
    import key_pkg::*;
#(
    parameter int unsigned N_KEYS = 8,
    parameter int unsigned DIV    = 50000,
    parameter int unsigned HIST   = 8,
    localparam int unsigned IW    = $clog2(N_KEYS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] keys_raw,
    output logic [N_KEYS-1:0] key_state,
    output logic              note_valid,
    output logic [IW-1:0]     note_idx,
    output logic              evt_valid,
    output logic              evt_press,
    output logic [IW-1:0]     evt_idx,
    input  logic              evt_ready,
    output logic              evt_ovf
);

    localparam int unsigned CW = $clog2(DIV);

    logic [N_KEYS-1:0] sync1;
    logic [N_KEYS-1:0] sample;
    logic [CW-1:0]     cnt;
    logic              tick;

    scan_state_t       state;
    scan_state_t       state_n;
    logic [IW-1:0]     idx;
    logic [IW-1:0]     idx_n;
    logic              scan_en;

    logic [HIST-1:0]   hist [N_KEYS];
    logic [HIST-1:0]   h_new;
    logic              key_next;
    logic              changed;

    evt_t              push_evt;
    evt_t              head;

    assign tick = (cnt == CW'(DIV - 1));

    always_comb begin
        state_n = state;
        idx_n   = idx;
        scan_en = 1'b0;
        case (state)
            IDLE: begin
                if (tick) begin
                    state_n = SCAN;
                    idx_n   = '0;
                end
            end
            SCAN: begin
                scan_en = 1'b1;
                if (idx == IW'(N_KEYS - 1)) begin
                    state_n = IDLE;
                    idx_n   = '0;
                end else begin
                    idx_n = idx + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                idx_n   = '0;
            end
        endcase
    end

    // Shared debounce datapath for whichever key the scan is on this cycle.
    always_comb begin
        h_new = {sample[idx], hist[idx][HIST-1:1]};
        if (&h_new) begin
            key_next = 1'b1;
        end else if (~|h_new) begin
            key_next = 1'b0;
        end else begin
            key_next = key_state[idx];
        end
        changed        = scan_en && (key_next != key_state[idx]);
        push_evt.press = key_next;
        push_evt.idx   = EVT_IDX_W'(idx);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1     <= '0;
            sample    <= '0;
            cnt       <= '0;
            state     <= IDLE;
            idx       <= '0;
            key_state <= '0;
            for (int unsigned k = 0; k < N_KEYS; k++) begin
                hist[k] <= '0;
            end
        end else begin
            sync1  <= keys_raw;
            sample <= sync1;
            cnt    <= tick ? '0 : cnt + 1'b1;
            state  <= state_n;
            idx    <= idx_n;
            if (scan_en) begin
                hist[idx]      <= h_new;
                key_state[idx] <= key_next;
            end
        end
    end

    // Index 0 has highest priority, so scan downward and let lower indices overwrite.
    always_comb begin
        note_valid = |key_state;
        note_idx   = '0;
        for (int unsigned i = N_KEYS; i > 0; i--) begin
            if (key_state[i-1]) begin
                note_idx = IW'(i - 1);
            end
        end
    end

    evt_fifo #(
        .WIDTH($bits(evt_t)),
        .DEPTH(EVT_DEPTH)
    ) u_evt_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (changed),
        .din  (push_evt),
        .pop  (evt_ready),
        .dout (head),
        .valid(evt_valid),
        .ovf  (evt_ovf)
    );

    assign evt_press = head.press;
    assign evt_idx   = IW'(head.idx);

endmodule

// File: tb/tb_key_scan_ctrl.sv
// Bench for key_scan_ctrl: directed scenarios plus random traffic, checked every cycle
// against a run-length debounce model and a queue-based event FIFO model.
module tb_key_scan_ctrl;

    localparam int unsigned NK = 4;
    localparam int unsigned DV = 6;
    localparam int unsigned HS = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] keys_raw = '0;
    logic       evt_ready = 1'b0;
    logic [3:0] key_state;
    logic       note_valid;
    logic [1:0] note_idx;
    logic       evt_valid;
    logic       evt_press;
    logic [1:0] evt_idx;
    logic       evt_ovf;

    always #5 clk = ~clk;

    key_scan_ctrl #(
        .N_KEYS(NK),
        .DIV   (DV),
        .HIST  (HS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .keys_raw  (keys_raw),
        .key_state (key_state),
        .note_valid(note_valid),
        .note_idx  (note_idx),
        .evt_valid (evt_valid),
        .evt_press (evt_press),
        .evt_idx   (evt_idx),
        .evt_ready (evt_ready),
        .evt_ovf   (evt_ovf)
    );

    typedef struct {
        bit p;
        int i;
    } ev_t;

    int         vectors = 0;
    int         miscompares = 0;

    // Model: raw values reach the debouncer two edges late; each key keeps the
    // length of its current run of identical samples.
    logic [3:0] rq[$];
    int         ph;
    bit         ticked;
    logic [3:0] m_ks;
    bit         m_last[NK];
    int         m_run[NK];
    ev_t        evq[$];
    bit         m_ovf;

    function automatic void model_reset();
        rq = {4'h0, 4'h0};
        ph = 0;
        ticked = 1'b0;
        m_ks = '0;
        for (int k = 0; k < NK; k++) begin
            m_last[k] = 1'b0;
            m_run[k]  = HS;
        end
        evq.delete();
        m_ovf = 1'b0;
    endfunction

    function automatic void model_edge();
        logic [3:0] s;
        bit pop;
        int pre_sz;
        int k;
        bit b;
        ev_t e;
        if (!rst) begin
            model_reset();
            return;
        end
        pre_sz = evq.size();
        pop = evt_ready && (pre_sz > 0);
        s = rq.pop_front();
        rq.push_back(keys_raw);
        if (pop) void'(evq.pop_front());
        if (ticked && ph < NK) begin
            k = ph;
            b = s[k];
            if (b == m_last[k]) begin
                if (m_run[k] < HS) m_run[k]++;
            end else begin
                m_last[k] = b;
                m_run[k] = 1;
            end
            if (m_run[k] >= HS && m_ks[k] != b) begin
                m_ks[k] = b;
                e.p = b;
                e.i = k;
                if (!pop && pre_sz == 4) m_ovf = 1'b1;
                else evq.push_back(e);
            end
        end
        if (ph == DV - 1) begin
            ph = 0;
            ticked = 1'b1;
        end else begin
            ph++;
        end
    endfunction

    function automatic bit would_push();
        int k;
        bit b;
        int run;
        if (!(rst && ticked && ph < NK)) return 1'b0;
        k = ph;
        b = rq[0][k];
        run = (b == m_last[k]) ? ((m_run[k] < HS) ? m_run[k] + 1 : HS) : 1;
        return (run >= HS) && (m_ks[k] != b);
    endfunction

    function automatic int lowest(input logic [3:0] v);
        for (int i = 0; i < NK; i++) if (v[i]) return i;
        return 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        chk("key_state", key_state, m_ks);
        chk("note_valid", note_valid, |m_ks);
        chk("note_idx", note_idx, lowest(m_ks));
        chk("evt_valid", evt_valid, evq.size() > 0);
        chk("evt_ovf", evt_ovf, m_ovf);
        if (evq.size() > 0) begin
            chk("evt_press", evt_press, evq[0].p);
            chk("evt_idx", evt_idx, evq[0].i);
        end
    endtask

    task automatic run(input int n);
        repeat (n) cyc();
    endtask

    initial begin
        bit hit;
        ev_t exp_list[4];
        model_reset();

        // Reset held with all keys asserted.
        rst = 1'b0;
        keys_raw = 4'hF;
        run(3);
        chk("rst_key_state", key_state, 4'h0);
        chk("rst_note", {note_valid, note_idx}, 3'b000);
        chk("rst_evt", {evt_valid, evt_press, evt_idx, evt_ovf}, 5'b00000);

        // Clean press of key 2.
        rst = 1'b1;
        keys_raw = 4'b0100;
        run(40);
        chk("press_key_state", key_state, 4'b0100);
        chk("press_note", {note_valid, note_idx}, 3'b110);
        chk("press_evt", {evt_valid, evt_press, evt_idx}, 4'b1110);
        evt_ready = 1'b1;
        run(1);
        evt_ready = 1'b0;
        chk("press_popped", evt_valid, 1'b0);

        // Key 1 bounces once per tick, then settles low.
        for (int t = 0; t < 10; t++) begin
            keys_raw[1] = ~keys_raw[1];
            run(DV);
        end
        keys_raw[1] = 1'b0;
        run(30);
        chk("bounce_key_state", key_state, 4'b0100);
        chk("bounce_no_evt", evt_valid, 1'b0);

        // Priority: keys 3 and 1 held, then key 1 released.
        evt_ready = 1'b1;
        keys_raw = 4'b1010;
        run(40);
        chk("prio_note_idx", note_idx, 2'd1);
        chk("prio_key_state", key_state, 4'b1010);
        evt_ready = 1'b0;
        keys_raw = 4'b1000;
        run(40);
        chk("release_note_idx", note_idx, 2'd3);
        chk("release_evt", {evt_valid, evt_press, evt_idx}, 4'b1001);
        evt_ready = 1'b1;
        run(2);
        evt_ready = 1'b0;

        // Five changes with no consumer: four kept, fifth dropped.
        keys_raw = 4'b1001; run(40);
        keys_raw = 4'b1011; run(40);
        keys_raw = 4'b1010; run(40);
        keys_raw = 4'b1000; run(40);
        keys_raw = 4'b0000; run(40);
        chk("full_ovf", evt_ovf, 1'b1);
        exp_list[0] = '{1'b1, 0};
        exp_list[1] = '{1'b1, 1};
        exp_list[2] = '{1'b0, 0};
        exp_list[3] = '{1'b0, 1};
        evt_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_valid", evt_valid, 1'b1);
            chk("drain_head", {evt_press, evt_idx}, {exp_list[i].p, 2'(exp_list[i].i)});
            run(1);
        end
        chk("drain_empty", evt_valid, 1'b0);
        evt_ready = 1'b0;

        // Push lands in the same cycle as a pop while full.
        rst = 1'b0;
        run(2);
        rst = 1'b1;
        keys_raw = 4'b0001; run(40);
        keys_raw = 4'b0000; run(40);
        keys_raw = 4'b0001; run(40);
        keys_raw = 4'b0000; run(40);
        chk("fill_valid", evt_valid, 1'b1);
        keys_raw = 4'b0010;
        hit = 1'b0;
        for (int n = 0; n < 60 && !hit; n++) begin
            if (would_push()) begin
                evt_ready = 1'b1;
                hit = 1'b1;
            end
            cyc();
            evt_ready = 1'b0;
        end
        chk("simul_reached", hit, 1'b1);
        chk("simul_ovf", evt_ovf, 1'b0);
        evt_ready = 1'b1;
        run(3);
        chk("simul_tail", {evt_valid, evt_press, evt_idx}, 4'b1101);
        run(1);
        chk("simul_empty", evt_valid, 1'b0);

        // Random traffic with one reset landing mid-scan.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 39) == 0) keys_raw = 4'($urandom);
            evt_ready = ($urandom_range(0, 3) != 0);
            if (i == 700) begin
                for (int n = 0; n < 20 && !(ticked && ph == 1); n++) cyc();
                rst = 1'b0;
                cyc();
                rst = 1'b1;
            end
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
